// File: rtl/score_writer_if.sv
// Bundle between the score writer and its environment: fill control, the cell-score
// handshake, the score RAM write port, and fill-progress status.
interface score_writer_if #(
   parameter int ADDR_W = 7
);
   // Handshake: a score is accepted on a rising edge where score_valid and score_ready are both high.
   // score_ready is registered, so the producer may sample it before that edge.
   logic                start;
   logic signed [8:0]   score_in;
   logic                score_valid;
   logic                score_ready;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic signed [8:0]   wdata;
   logic [3:0]          cur_i;
   logic [3:0]          cur_j;
   logic                init_done;
   logic                done;

   modport master (
      output start, score_in, score_valid,
      input  score_ready, we, waddr, wdata, cur_i, cur_j, init_done, done
   );

   modport slave (
      input  start, score_in, score_valid,
      output score_ready, we, waddr, wdata, cur_i, cur_j, init_done, done
   );
endinterface

// File: rtl/score_writer.sv
// Fills an (N+1)x(N+1) score matrix: writes the gap-penalty border, then streams
// accepted cell scores into the RAM in row-major order.
module score_writer #(
   parameter int N      = 8,
   parameter int GAP    = -2,
   parameter int ADDR_W = 7
) (
   input  logic         clk,
   input  logic         rst,
   score_writer_if.slave bus,
   output logic [2:0]   state_o
);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_INIT_ROW   = 3'd1;
   localparam logic [2:0] S_INIT_COL   = 3'd2;
   localparam logic [2:0] S_WAIT_CELL  = 3'd3;
   localparam logic [2:0] S_WRITE_CELL = 3'd4;
   localparam logic [2:0] S_DONE       = 3'd5;

   localparam logic signed [8:0] GAP9 = 9'(GAP);
   localparam logic [3:0]        N4   = 4'(N);

   logic [2:0]          state_q, state_d;
   logic [3:0]          i_q, i_d, j_q, j_d;
   logic signed [8:0]   acc_q, acc_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic signed [8:0]   wdata_q, wdata_d;
   logic                ready_q, ready_d;
   logic                init_done_q, init_done_d;
   logic                done_q, done_d;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] i, input logic [3:0] j);
      return ADDR_W'(i) * ADDR_W'(N + 1) + ADDR_W'(j);
   endfunction

   // The write registers are loaded on the edge entering a cycle, so acc_q always
   // holds the border value of the next write rather than the one on the bus.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      acc_d       = acc_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      ready_d     = 1'b0;
      init_done_d = init_done_q;
      done_d      = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d     = S_INIT_ROW;
               i_d         = 4'd0;
               j_d         = 4'd0;
               acc_d       = GAP9;
               we_d        = 1'b1;
               waddr_d     = '0;
               wdata_d     = '0;
               init_done_d = 1'b0;
               done_d      = 1'b0;
            end
         end
         S_INIT_ROW: begin
            we_d = 1'b1;
            if (j_q == N4) begin
               state_d = S_INIT_COL;
               i_d     = 4'd1;
               j_d     = 4'd0;
               waddr_d = addr_of(4'd1, 4'd0);
               wdata_d = GAP9;
               acc_d   = GAP9 + GAP9;
            end else begin
               j_d     = j_q + 4'd1;
               waddr_d = addr_of(4'd0, j_q + 4'd1);
               wdata_d = acc_q;
               acc_d   = acc_q + GAP9;
            end
         end
         S_INIT_COL: begin
            if (i_q == N4) begin
               state_d     = S_WAIT_CELL;
               init_done_d = 1'b1;
               i_d         = 4'd1;
               j_d         = 4'd1;
               ready_d     = 1'b1;
            end else begin
               we_d    = 1'b1;
               i_d     = i_q + 4'd1;
               waddr_d = addr_of(i_q + 4'd1, 4'd0);
               wdata_d = acc_q;
               acc_d   = acc_q + GAP9;
            end
         end
         S_WAIT_CELL: begin
            ready_d = 1'b1;
            if (bus.score_valid && ready_q) begin
               state_d = S_WRITE_CELL;
               ready_d = 1'b0;
               we_d    = 1'b1;
               waddr_d = addr_of(i_q, j_q);
               wdata_d = bus.score_in;
            end
         end
         S_WRITE_CELL: begin
            if (i_q == N4 && j_q == N4) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_WAIT_CELL;
               ready_d = 1'b1;
               if (j_q < N4) begin
                  j_d = j_q + 4'd1;
               end else begin
                  j_d = 4'd1;
                  i_d = i_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         init_done_q <= init_done_d;
         done_q      <= done_d;
      end
   end

   assign bus.score_ready = ready_q;
   assign bus.we          = we_q;
   assign bus.waddr       = waddr_q;
   assign bus.wdata       = wdata_q;
   assign bus.cur_i       = i_q;
   assign bus.cur_j       = j_q;
   assign bus.init_done   = init_done_q;
   assign bus.done        = done_q;
   assign state_o         = state_q;
endmodule

// File: doc/score_writer.md
SCORE_WRITER -- requirements
Module: score_writer

Interface
REQ-001 Parameter N, default 8: sequence length; the score matrix is (N+1) x (N+1), stored row-major.
REQ-002 Parameter GAP, default -2: signed gap penalty used for the row-0 and column-0 init values.
REQ-003 Parameter ADDR_W, default 7: write address width; it SHALL satisfy 2^ADDR_W >= (N+1)^2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a matrix fill.
REQ-007 score_in  input  9  signed cell score from the compute unit.
REQ-008 score_valid  input  1  score_in is valid this cycle.
REQ-009 score_ready  output  1  the block accepts score_in this cycle.
REQ-010 we  output  1  score RAM write enable.
REQ-011 waddr  output  ADDR_W  score RAM write address.
REQ-012 wdata  output  9  signed score RAM write data.
REQ-013 cur_i  output  4  row index of the next cell to be accepted; drives the read-side address generator.
REQ-014 cur_j  output  4  column index of the next cell to be accepted.
REQ-015 init_done  output  1  high once row 0 and column 0 are written; held until rst or start.
REQ-016 done  output  1  high once all cells are written; held until rst or start.

Function
REQ-017 States SHALL be IDLE, INIT_ROW, INIT_COL, WAIT_CELL, WRITE_CELL and DONE.
REQ-018 All outputs SHALL be registered; waddr SHALL equal i*(N+1)+j for the (i,j) being written.
REQ-019 start in IDLE or DONE SHALL clear init_done and done, set i=0, j=0 and an accumulator to 0, and enter INIT_ROW.
REQ-020 start in any other state SHALL be ignored.
REQ-021 INIT_ROW SHALL issue one write per cycle for (0,j), j=0..N, with wdata=j*GAP; the value comes from adding GAP to the accumulator each cycle, with no multiplier.
REQ-022 After the (0,N) write, INIT_ROW SHALL enter INIT_COL with i=1, j=0 and the accumulator set to GAP.
REQ-023 INIT_COL SHALL issue one write per cycle for (i,0), i=1..N, with wdata=i*GAP.
REQ-024 After the (N,0) write, INIT_COL SHALL set init_done, set cur_i=1 and cur_j=1, and enter WAIT_CELL.
REQ-025 The init phase SHALL take exactly 2N+1 consecutive we cycles.
REQ-026 In WAIT_CELL, score_ready SHALL be 1; in every other state it SHALL be 0.
REQ-027 Acceptance SHALL occur when score_valid and score_ready are both high on a rising edge.
REQ-028 On acceptance, the next cycle SHALL present we=1, waddr=addr(cur_i,cur_j) and wdata=score_in, in state WRITE_CELL.
REQ-029 Accept-to-write latency SHALL be 1 cycle; peak throughput SHALL be one cell per 2 cycles.
REQ-030 Leaving WRITE_CELL SHALL advance the index: if cur_j<N then cur_j+1; otherwise cur_j=1 and cur_i+1.
REQ-031 If the cell just written is (N,N), WRITE_CELL SHALL enter DONE and set done=1; otherwise it SHALL return to WAIT_CELL.
REQ-032 score_valid held high through WRITE_CELL SHALL NOT cause a second acceptance; the next acceptance is the next WAIT_CELL cycle.
REQ-033 we SHALL be 0 in IDLE, WAIT_CELL and DONE.
REQ-034 score_valid SHALL be ignored outside WAIT_CELL.
REQ-035 wdata SHALL pass score_in without modification; the init values SHALL be computed in 9-bit signed arithmetic. For the defaults, min -16, no overflow.

Reset
REQ-036 rst SHALL force IDLE and drive we, waddr, wdata, score_ready, init_done, done, cur_i and cur_j to 0, and clear the accumulator.
REQ-037 rst SHALL take priority over start and score_valid in the same cycle.
REQ-038 rst mid-fill SHALL abandon the fill; the first write after a following start SHALL be addr 0 with data 0.

Verification
REQ-039 Reset with N=8, GAP=-2 -> all outputs 0, state IDLE, score_ready=0.
REQ-040 start pulse -> 17 consecutive we cycles: addr 0 data 0, addr 1 data -2, ..., addr 8 data -16, addr 9 data -2, addr 18 data -4, ..., addr 72 data -16; then init_done=1, cur_i=1, cur_j=1.
REQ-041 score_in=5 with valid at (1,1) -> next cycle we=1, addr 10, data 5; after 8 cells cur_i=2, cur_j=1, and the next write is to addr 19.
REQ-042 score_valid held high for 4 cycles -> exactly 2 acceptances and writes to addr 10 and 11; score_ready toggles 1,0,1,0.
REQ-043 64 cells, the last score_in=-7 -> final write addr 80 data -7, done=1 and held; a new start clears done and rewrites addr 0 with data 0.
REQ-044 rst asserted during INIT_COL, then start -> outputs 0 during reset; the restart sequence is identical to REQ-040.
